// File: rtl/count_sequencer.sv
// count_sequencer
//   Steps one `count` timer through a programmable table of {mode, match_value}
//   intervals. The counter is restarted for each step. The whole table is
//   repeated for a programmed number of passes, and then completion is signalled.
//
// Optional feature:
//   COUNT_SEQ_OVF_ABORT_EN - when defined, a counter overflow that arrives before
//   the match aborts the sequence and sets the sticky err flag. When it is not
//   defined, cnt_ovf is ignored and err is tied low.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_data  table write port; data = {mode[1:0], match[BIN-1:0]}
//   cfg_last, repeat_n        last table index and pass count, sampled at start
//   start, stop               begin a sequence / abort it (stop wins)
//   cnt_reset_n, cnt_enable,
//   cnt_mode, cnt_match_val   drive the counter
//   cnt_match, cnt_ovf        status from the counter
//   step, step_pulse          current table index, 1-cycle step-complete pulse
//   busy, done, err           sequence active, completion pulse, overflow abort
module count_sequencer #(
    parameter int BIN   = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [BIN+1:0] cfg_data,
    input  logic [AW-1:0]  cfg_last,
    input  logic [7:0]     repeat_n,
    input  logic           start,
    input  logic           stop,
    output logic           cnt_reset_n,
    output logic           cnt_enable,
    output logic [1:0]     cnt_mode,
    output logic [BIN-1:0] cnt_match_val,
    input  logic           cnt_match,
    input  logic           cnt_ovf,
    output logic [AW-1:0]  step,
    output logic           step_pulse,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   last_sh;
    logic [7:0]      rep_sh;
    logic [7:0]      pass;
    logic [8:0]      pass_inc;
    logic            ovf_abort;
    logic [BIN+1:0]  tbl [DEPTH];

    assign pass_inc = {1'b0, pass} + 9'd1;

`ifdef COUNT_SEQ_OVF_ABORT_EN
    logic err_q;
    assign ovf_abort = cnt_ovf;
    assign err       = err_q;
`else
    logic unused_ovf;
    assign unused_ovf = cnt_ovf;
    assign ovf_abort  = 1'b0;
    assign err        = 1'b0;
`endif

    // Table storage, not reset. Because a LOAD in the same cycle as a write
    // sees the old word, a write to a later step takes effect when that step loads.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // idx is the working table index. The step output is copied from it in LOAD.
    // As a result, step_pulse shows the index of the step that just completed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt_reset_n   <= 1'b0;
            cnt_enable    <= 1'b0;
            cnt_mode      <= '0;
            cnt_match_val <= '0;
            step          <= '0;
            idx           <= '0;
            step_pulse    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= '0;
            last_sh       <= '0;
            rep_sh        <= '0;
`ifdef COUNT_SEQ_OVF_ABORT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                cnt_enable  <= 1'b0;
                cnt_reset_n <= 1'b1;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_enable  <= 1'b0;
                        cnt_reset_n <= 1'b1;
                        if (start) begin
                            state   <= LOAD;
                            busy    <= 1'b1;
                            idx     <= '0;
                            step    <= '0;
                            pass    <= '0;
                            last_sh <= cfg_last;
                            rep_sh  <= repeat_n;
`ifdef COUNT_SEQ_OVF_ABORT_EN
                            err_q   <= 1'b0;
`endif
                        end
                    end
                    LOAD: begin
                        cnt_reset_n                <= 1'b0;
                        cnt_enable                 <= 1'b0;
                        {cnt_mode, cnt_match_val}  <= tbl[idx];
                        step                       <= idx;
                        state                      <= RUN;
                    end
                    RUN: begin
                        cnt_reset_n <= 1'b1;
                        cnt_enable  <= 1'b1;
                        if (cnt_match) begin
                            state <= NEXT;
                        end else if (ovf_abort) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            cnt_enable <= 1'b0;
`ifdef COUNT_SEQ_OVF_ABORT_EN
                            err_q      <= 1'b1;
`endif
                        end
                    end
                    NEXT: begin
                        cnt_enable <= 1'b0;
                        step_pulse <= 1'b1;
                        if (idx < last_sh) begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end else begin
                            pass <= pass_inc[7:0];
                            if (rep_sh == 8'd0 || pass_inc < {1'b0, rep_sh}) begin
                                idx   <= '0;
                                state <= LOAD;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer
//   Directed bench for count_sequencer. It contains a behavioural 8-bit-top
//   counter (top 255). The stimulus pushes the expected step events into a
//   queue. A monitor pops one entry for each step_pulse/done and compares it.
//   The expected counter value at each step_pulse is match+2, because the
//   counter keeps running through the match cycle and the NEXT cycle.
module tb_count_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [33:0] cfg_data;
    logic [2:0]  cfg_last;
    logic [7:0]  repeat_n;
    logic        start;
    logic        stop;
    logic        cnt_reset_n;
    logic        cnt_enable;
    logic [1:0]  cnt_mode;
    logic [31:0] cnt_match_val;
    logic        cnt_match;
    logic        cnt_ovf;
    logic [2:0]  step;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  step;
        logic        done;
        logic        busy;
        logic [31:0] cnt;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    count_sequencer #(.BIN(32), .DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .repeat_n(repeat_n),
        .start(start), .stop(stop),
        .cnt_reset_n(cnt_reset_n), .cnt_enable(cnt_enable),
        .cnt_mode(cnt_mode), .cnt_match_val(cnt_match_val),
        .cnt_match(cnt_match), .cnt_ovf(cnt_ovf),
        .step(step), .step_pulse(step_pulse),
        .busy(busy), .done(done), .err(err)
    );

    // Counter model, counting up or down between 0 and 255.
    logic [31:0] cnt = '0;
    always @(posedge clk) begin
        if (!cnt_reset_n) cnt <= '0;
        else if (cnt_enable) begin
            if (!cnt_mode[0]) cnt <= (cnt == 32'd255) ? 32'd0 : cnt + 32'd1;
            else              cnt <= (cnt == 32'd0) ? 32'd255 : cnt - 32'd1;
        end
    end
    assign cnt_match = cnt_enable && cnt_reset_n && (cnt == cnt_match_val);
    assign cnt_ovf   = cnt_enable && cnt_reset_n &&
                       (cnt_mode[0] ? (cnt == 32'd0) : (cnt == 32'd255));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input logic [2:0] s, input logic d, input logic b,
                                    input logic [31:0] c);
        ev_t e;
        e.step = s; e.done = d; e.busy = b; e.cnt = c;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (step_pulse || done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {62'd0, step_pulse, done}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("sb_pulse", step_pulse, 1);
                chk("sb_step", step, e.step);
                chk("sb_done", done, e.done);
                chk("sb_busy", busy, e.busy);
                chk("sb_cnt", cnt, e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [1:0] m, input logic [31:0] v);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = {m, v};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] last, input logic [7:0] rep);
        cfg_last = last; repeat_n = rep; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_last = '0; repeat_n = '0; start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        chk("rst_cnt_reset_n", cnt_reset_n, 0);
        chk("rst_cnt_enable", cnt_enable, 0);
        chk("rst_cnt_mode", cnt_mode, 0);
        chk("rst_match_val", cnt_match_val, 0);
        chk("rst_step", step, 0);
        chk("rst_busy_done_pulse_err", {busy, done, step_pulse, err}, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_cnt_reset_n", cnt_reset_n, 1);

        // start and stop together in IDLE: stay IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        tick();
        chk("startstop_no_load", cnt_reset_n, 1);

        // 1: two steps, single pass, latency
        cfg_write(3'd0, 2'b00, 32'd5);
        cfg_write(3'd1, 2'b00, 32'd3);
        push_ev(3'd0, 1'b0, 1'b1, 32'd7);
        push_ev(3'd1, 1'b1, 1'b0, 32'd5);
        do_start(3'd1, 8'd1);
        chk("t1_busy", busy, 1);
        chk("t1_reset_n_n0", cnt_reset_n, 1);
        tick();
        chk("t1_reset_n_n1", cnt_reset_n, 0);
        chk("t1_enable_n1", cnt_enable, 0);
        chk("t1_match_val", cnt_match_val, 5);
        tick();
        chk("t1_reset_n_n2", cnt_reset_n, 1);
        chk("t1_enable_n2", cnt_enable, 1);
        wait_idle("t1_idle", 100);
        drain("t1_drain", 10);

        // 2: one step, three passes, count LOAD cycles
        begin
            int loads = 0;
            int n = 0;
            cfg_write(3'd0, 2'b00, 32'd4);
            push_ev(3'd0, 1'b0, 1'b1, 32'd6);
            push_ev(3'd0, 1'b0, 1'b1, 32'd6);
            push_ev(3'd0, 1'b1, 1'b0, 32'd6);
            do_start(3'd0, 8'd3);
            while (busy && n < 200) begin
                tick();
                n++;
                if (!cnt_reset_n) loads++;
            end
            chk("t2_idle", busy, 0);
            chk("t2_loads", loads, 3);
            drain("t2_drain", 10);
        end

        // 3: infinite passes, stop after ten steps
        cfg_write(3'd0, 2'b00, 32'd2);
        cfg_write(3'd1, 2'b00, 32'd3);
        for (int i = 0; i < 10; i++) begin
            push_ev(3'(i % 2), 1'b0, 1'b1, (i % 2 == 0) ? 32'd4 : 32'd5);
        end
        do_start(3'd1, 8'd0);
        drain("t3_drain", 200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_enable", cnt_enable, 0);
        chk("t3_stop_step", step, 0);
        repeat (10) tick();
        chk("t3_still_idle", busy, 0);

        // 4: reset in the middle of step 1, then restart from step 0
        cfg_write(3'd0, 2'b00, 32'd5);
        cfg_write(3'd1, 2'b00, 32'd30);
        push_ev(3'd0, 1'b0, 1'b1, 32'd7);
        do_start(3'd1, 8'd1);
        drain("t4_drain0", 100);
        repeat (4) tick();
        chk("t4_in_step1", step, 1);
        chk("t4_running", cnt_enable, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t4_rst_ctl", {cnt_reset_n, cnt_enable, cnt_mode}, 0);
        chk("t4_rst_match_val", cnt_match_val, 0);
        chk("t4_rst_step", step, 0);
        chk("t4_rst_flags", {busy, done, step_pulse, err}, 0);
        tick();
        push_ev(3'd0, 1'b0, 1'b1, 32'd7);
        push_ev(3'd1, 1'b1, 1'b0, 32'd32);
        do_start(3'd1, 8'd1);
        wait_idle("t4_idle", 200);
        drain("t4_drain", 10);

        // 5: match value never reached; overflow behaviour depends on the build
        cfg_write(3'd0, 2'b00, 32'd300);
        do_start(3'd0, 8'd1);
`ifdef COUNT_SEQ_OVF_ABORT_EN
        wait_idle("t5_abort_idle", 400);
        chk("t5_err", err, 1);
        chk("t5_no_done", done, 0);
`else
        repeat (300) tick();
        chk("t5_still_busy", busy, 1);
        chk("t5_err", err, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_busy", busy, 0);
`endif

        // 6: start while busy is ignored; rewriting entry 1 during step 0 takes effect
        cfg_write(3'd0, 2'b00, 32'd20);
        cfg_write(3'd1, 2'b00, 32'd3);
        push_ev(3'd0, 1'b0, 1'b1, 32'd22);
        push_ev(3'd1, 1'b1, 1'b0, 32'd9);
        do_start(3'd1, 8'd1);
        chk("t6_err_cleared", err, 0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy", busy, 1);
        tick();
        chk("t6_no_restart_a", cnt_reset_n, 1);
        tick();
        chk("t6_no_restart_b", cnt_reset_n, 1);
        cfg_write(3'd1, 2'b00, 32'd7);
        wait_idle("t6_idle", 200);
        chk("t6_match_val", cnt_match_val, 7);
        drain("t6_drain", 10);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
